// File: rtl/sha3_lite_axil_slave_if.sv
// AXI4-Lite bus bundle between the block-design interconnect and the SHA3 lite
// register slave.
interface sha3_lite_axil_slave_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/sha3_lite_axil_slave.sv
// AXI4-Lite register slave for the SHA3 lite core: control/length/message writes,
// message word streaming, status and 42-word digest readback.
module sha3_lite_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int DIGEST_WORDS       = 42
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  sha3_lite_axil_slave_if.slave               s00_axi,
  output logic                                start_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       msg_len_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       msg_data_o,
  output logic                                msg_valid_o,
  input  logic                                msg_ready_i,
  input  logic                                busy_i,
  input  logic                                done_i,
  input  logic [C_S_AXI_DATA_WIDTH*DIGEST_WORDS-1:0] digest_i
);
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int PTR_W = $clog2(DIGEST_WORDS);

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_LEN    = 3'd1;
  localparam logic [2:0] REG_DATA   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_DIGEST = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic            aw_full_q, aw_full_d;
  logic [2:0]      aw_idx_q, aw_idx_d;
  logic            w_full_q, w_full_d;
  logic [DW-1:0]   w_data_q, w_data_d;
  logic [DW/8-1:0] w_strb_q, w_strb_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [DW-1:1]   ctrl_q, ctrl_d;
  logic [DW-1:0]   len_q, len_d;
  logic [DW-1:0]   msg_data_q, msg_data_d;
  logic            msg_valid_q, msg_valid_d;
  logic            start_q, start_d;
  logic            done_q, done_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [DW-1:0]   digest_q [DIGEST_WORDS];
  logic [DW-1:0]   digest_d [DIGEST_WORDS];

  logic            aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic [2:0]      wr_idx, ar_idx;
  logic [DW-1:0]   wr_data;
  logic [DW/8-1:0] wr_strb;
  logic            msg_stall, wr_exec;
  logic [DW-1:0]   status_word;
  logic            unused_ok;

  // Ready lines are gated by reset so they read 0 while reset is held.
  assign s00_axi.awready = s00_axi_aresetn & ~aw_full_q & ~bvalid_q;
  assign s00_axi.wready  = s00_axi_aresetn & ~w_full_q & ~bvalid_q;
  assign s00_axi.arready = s00_axi_aresetn & ~rvalid_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = bresp_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = rresp_q;

  assign start_o     = start_q;
  assign msg_len_o   = len_q;
  assign msg_data_o  = msg_data_q;
  assign msg_valid_o = msg_valid_q;

  assign aw_hs = s00_axi.awvalid & s00_axi.awready;
  assign w_hs  = s00_axi.wvalid & s00_axi.wready;
  assign ar_hs = s00_axi.arvalid & s00_axi.arready;
  assign b_hs  = bvalid_q & s00_axi.bready;
  assign r_hs  = rvalid_q & s00_axi.rready;

  // A channel arriving this cycle counts as present, so AW+W together execute at once.
  assign wr_idx  = aw_full_q ? aw_idx_q : s00_axi.awaddr[AW-1:2];
  assign wr_data = w_full_q ? w_data_q : s00_axi.wdata;
  assign wr_strb = w_full_q ? w_strb_q : s00_axi.wstrb;
  assign ar_idx  = s00_axi.araddr[AW-1:2];

  assign msg_stall = (wr_idx == REG_DATA) & msg_valid_q & ~msg_ready_i;
  assign wr_exec   = (aw_full_q | aw_hs) & (w_full_q | w_hs) & ~msg_stall;

  assign status_word = {{(DW-PTR_W-8){1'b0}}, ptr_q, 5'd0, msg_valid_q, done_q, busy_i};

  assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot,
                       s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

  for (genvar gi = 0; gi < DIGEST_WORDS; gi++) begin : g_digest
    assign digest_d[gi] = done_i ? digest_i[gi*DW +: DW] : digest_q[gi];
  end

  always_comb begin
    aw_full_d   = aw_full_q;
    aw_idx_d    = aw_idx_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    ctrl_d      = ctrl_q;
    len_d       = len_q;
    msg_data_d  = msg_data_q;
    msg_valid_d = msg_valid_q & ~msg_ready_i;
    start_d     = 1'b0;
    done_d      = done_q;
    ptr_d       = ptr_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s00_axi.awaddr[AW-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s00_axi.wdata;
      w_strb_d = s00_axi.wstrb;
    end
    if (b_hs) bvalid_d = 1'b0;

    if (wr_exec) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      case (wr_idx)
        REG_CTRL: begin
          ctrl_d = wr_data[DW-1:1];
          if (wr_data[0]) begin
            start_d = 1'b1;
            done_d  = 1'b0;
          end
        end
        REG_LEN: begin
          for (int b = 0; b < DW/8; b++) begin
            if (wr_strb[b]) len_d[8*b +: 8] = wr_data[8*b +: 8];
          end
        end
        REG_DATA: begin
          msg_data_d  = wr_data;
          msg_valid_d = 1'b1;
        end
        REG_STATUS, REG_DIGEST: ;
        default: bresp_d = RESP_SLVERR;
      endcase
    end

    if (r_hs) rvalid_d = 1'b0;

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      case (ar_idx)
        REG_CTRL:   rdata_d = {ctrl_q, 1'b0};
        REG_LEN:    rdata_d = len_q;
        REG_DATA:   rdata_d = msg_data_q;
        REG_STATUS: rdata_d = status_word;
        REG_DIGEST: begin
          rdata_d = digest_q[ptr_q];
          ptr_d   = (ptr_q == PTR_W'(DIGEST_WORDS-1)) ? '0 : ptr_q + 1'b1;
        end
        default: begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end

    // A completing hash wins over a same-cycle start clear and pointer advance.
    if (done_i) begin
      done_d = 1'b1;
      ptr_d  = '0;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_full_q   <= 1'b0;
      aw_idx_q    <= '0;
      w_full_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      ctrl_q      <= '0;
      len_q       <= '0;
      msg_data_q  <= '0;
      msg_valid_q <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      ptr_q       <= '0;
      for (int i = 0; i < DIGEST_WORDS; i++) digest_q[i] <= '0;
    end else begin
      aw_full_q   <= aw_full_d;
      aw_idx_q    <= aw_idx_d;
      w_full_q    <= w_full_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      ctrl_q      <= ctrl_d;
      len_q       <= len_d;
      msg_data_q  <= msg_data_d;
      msg_valid_q <= msg_valid_d;
      start_q     <= start_d;
      done_q      <= done_d;
      ptr_q       <= ptr_d;
      digest_q    <= digest_d;
    end
  end
endmodule

// File: tb/tb_sha3_lite_axil_slave.sv
// Directed bench for sha3_lite_axil_slave: register access, channel skew, message
// backpressure, digest readback, unmapped access and mid-transaction reset.
module tb_sha3_lite_axil_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha3_lite_axil_slave_if s00_axi ();

  logic          start_o;
  logic [31:0]   msg_len_o;
  logic [31:0]   msg_data_o;
  logic          msg_valid_o;
  logic          msg_ready_i = 1'b0;
  logic          busy_i = 1'b0;
  logic          done_i = 1'b0;
  logic [1343:0] digest_i = '0;

  sha3_lite_axil_slave dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .s00_axi        (s00_axi),
    .start_o        (start_o),
    .msg_len_o      (msg_len_o),
    .msg_data_o     (msg_data_o),
    .msg_valid_o    (msg_valid_o),
    .msg_ready_i    (msg_ready_i),
    .busy_i         (busy_i),
    .done_i         (done_i),
    .digest_i       (digest_i)
  );

  int n_checks = 0;
  int n_pass = 0;
  int start_cnt = 0;
  logic [31:0] core_q[$];

  always @(negedge clk) if (start_o) start_cnt++;
  always @(negedge clk) if (rst_n && msg_valid_o && msg_ready_i) core_q.push_back(msg_data_o);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic b_accept();
    s00_axi.bready = 1'b1;
    @(posedge clk); #1;
    s00_axi.bready = 1'b0;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    logic aw_ok, w_ok;
    @(negedge clk);
    s00_axi.awaddr = a; s00_axi.awvalid = 1'b1;
    s00_axi.wdata = d; s00_axi.wstrb = s; s00_axi.wvalid = 1'b1;
    n = 0;
    while ((s00_axi.awvalid || s00_axi.wvalid) && n < 100) begin
      aw_ok = s00_axi.awready; w_ok = s00_axi.wready;
      @(posedge clk); #1;
      if (aw_ok) s00_axi.awvalid = 1'b0;
      if (w_ok) s00_axi.wvalid = 1'b0;
      @(negedge clk); n++;
    end
    while (!s00_axi.bvalid && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) begin
      check_eq($sformatf("wr_timeout_%02h", a), 32'd0, 32'd1);
      s00_axi.awvalid = 1'b0; s00_axi.wvalid = 1'b0;
      resp = 2'b11;
      return;
    end
    resp = s00_axi.bresp;
    b_accept();
    $display("wr addr=0x%02h data=0x%08h strb=%b resp=%b", a, d, s, resp);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic ar_ok;
    @(negedge clk);
    s00_axi.araddr = a; s00_axi.arvalid = 1'b1;
    n = 0;
    while (s00_axi.arvalid && n < 100) begin
      ar_ok = s00_axi.arready;
      @(posedge clk); #1;
      if (ar_ok) s00_axi.arvalid = 1'b0;
      @(negedge clk); n++;
    end
    while (!s00_axi.rvalid && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) begin
      check_eq($sformatf("rd_timeout_%02h", a), 32'd0, 32'd1);
      s00_axi.arvalid = 1'b0;
      data = 32'hDEAD_BEEF; resp = 2'b11;
      return;
    end
    data = s00_axi.rdata; resp = s00_axi.rresp;
    s00_axi.rready = 1'b1;
    @(posedge clk); #1;
    s00_axi.rready = 1'b0;
    $display("rd addr=0x%02h data=0x%08h resp=%b", a, data, resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs, ws;

    s00_axi.awaddr = '0; s00_axi.awprot = '0; s00_axi.awvalid = 1'b0;
    s00_axi.wdata = '0; s00_axi.wstrb = '0; s00_axi.wvalid = 1'b0;
    s00_axi.bready = 1'b0;
    s00_axi.araddr = '0; s00_axi.arprot = '0; s00_axi.arvalid = 1'b0;
    s00_axi.rready = 1'b0;
    for (int k = 0; k < 42; k++) digest_i[k*32 +: 32] = 32'h100 + k;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_readies", {29'd0, s00_axi.awready, s00_axi.wready, s00_axi.arready}, 32'd0);
    check_eq("rst_valids", {28'd0, s00_axi.bvalid, s00_axi.rvalid, msg_valid_o, start_o}, 32'd0);
    check_eq("rst_msg_len", msg_len_o, 32'd0);
    check_eq("rst_rdata", s00_axi.rdata, 32'd0);
    rst_n = 1'b1;

    // Register readback
    axi_write(5'h00, 32'h0000_0002, 4'hF, ws); check_eq("ctrl_wr_resp", {30'd0, ws}, 32'd0);
    axi_write(5'h04, 32'h0000_0040, 4'hF, ws); check_eq("len_wr_resp", {30'd0, ws}, 32'd0);
    axi_read(5'h00, rd, rs); check_eq("ctrl_rd", rd, 32'h2); check_eq("ctrl_rresp", {30'd0, rs}, 32'd0);
    axi_read(5'h04, rd, rs); check_eq("len_rd", rd, 32'h40); check_eq("len_rresp", {30'd0, rs}, 32'd0);
    check_eq("msg_len_o", msg_len_o, 32'h40);
    check_eq("no_start", start_cnt, 32'd0);

    // AW three cycles ahead of W, byte strobe on byte 1
    @(negedge clk);
    s00_axi.awaddr = 5'h04; s00_axi.awvalid = 1'b1;
    @(posedge clk); #1; s00_axi.awvalid = 1'b0;
    @(negedge clk);
    check_eq("skew_awready_held", {31'd0, s00_axi.awready}, 32'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_eq("skew_bvalid_pre", {31'd0, s00_axi.bvalid}, 32'd0);
    s00_axi.wdata = 32'hAABB_CCDD; s00_axi.wstrb = 4'b0010; s00_axi.wvalid = 1'b1;
    @(posedge clk); #1; s00_axi.wvalid = 1'b0;
    @(negedge clk);
    check_eq("skew_bvalid", {31'd0, s00_axi.bvalid}, 32'd1);
    b_accept();
    $display("wr addr=0x04 data=0xaabbccdd strb=0010 (skewed)");
    axi_read(5'h04, rd, rs); check_eq("strb_len_rd", rd, 32'h0000_CC40);

    // Message backpressure
    msg_ready_i = 1'b0;
    axi_write(5'h08, 32'h1111_1111, 4'hF, ws);
    check_eq("bp_first_valid", {31'd0, msg_valid_o}, 32'd1);
    @(negedge clk);
    s00_axi.awaddr = 5'h08; s00_axi.awvalid = 1'b1;
    s00_axi.wdata = 32'h2222_2222; s00_axi.wstrb = 4'hF; s00_axi.wvalid = 1'b1;
    @(posedge clk); #1; s00_axi.awvalid = 1'b0; s00_axi.wvalid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("bp_bvalid_withheld", {31'd0, s00_axi.bvalid}, 32'd0);
    check_eq("bp_data_held", msg_data_o, 32'h1111_1111);
    @(posedge clk); #1; msg_ready_i = 1'b1;
    @(posedge clk); #1; msg_ready_i = 1'b0;
    @(negedge clk);
    check_eq("bp_bvalid_release", {31'd0, s00_axi.bvalid}, 32'd1);
    check_eq("bp_data_second", msg_data_o, 32'h2222_2222);
    check_eq("bp_valid_kept", {31'd0, msg_valid_o}, 32'd1);
    b_accept();
    $display("wr addr=0x08 data=0x22222222 strb=1111 (backpressured)");
    @(posedge clk); #1; msg_ready_i = 1'b1;
    @(posedge clk); #1; msg_ready_i = 1'b0;
    @(negedge clk);
    check_eq("bp_valid_drained", {31'd0, msg_valid_o}, 32'd0);
    check_eq("bp_core_count", core_q.size(), 32'd2);
    if (core_q.size() == 2) begin
      check_eq("bp_core_word0", core_q[0], 32'h1111_1111);
      check_eq("bp_core_word1", core_q[1], 32'h2222_2222);
    end

    // Start pulse, same-cycle AW+W latency
    @(negedge clk);
    s00_axi.awaddr = 5'h00; s00_axi.awvalid = 1'b1;
    s00_axi.wdata = 32'h1; s00_axi.wstrb = 4'hF; s00_axi.wvalid = 1'b1;
    @(posedge clk); #1; s00_axi.awvalid = 1'b0; s00_axi.wvalid = 1'b0;
    @(negedge clk);
    check_eq("start_bvalid", {31'd0, s00_axi.bvalid}, 32'd1);
    check_eq("start_pulse", {31'd0, start_o}, 32'd1);
    b_accept();
    $display("wr addr=0x00 data=0x00000001 strb=1111 (start)");
    @(negedge clk);
    check_eq("start_low", {31'd0, start_o}, 32'd0);
    check_eq("start_cnt_1", start_cnt, 32'd1);

    // Digest capture and readback with wrap
    @(posedge clk); #1; done_i = 1'b1;
    @(posedge clk); #1; done_i = 1'b0;
    axi_read(5'h0C, rd, rs); check_eq("status_done", rd, 32'h0000_0002);
    for (int i = 0; i < 43; i++) begin
      axi_read(5'h10, rd, rs);
      check_eq($sformatf("digest_%0d", i), rd, 32'h100 + (i % 42));
    end
    axi_read(5'h0C, rd, rs); check_eq("status_ptr1", rd, 32'h0000_0102);
    axi_write(5'h00, 32'h1, 4'hF, ws);
    axi_read(5'h0C, rd, rs); check_eq("status_done_clr", rd, 32'h0000_0100);
    check_eq("start_cnt_2", start_cnt, 32'd2);

    // Unmapped access
    axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, ws); check_eq("unmap_bresp", {30'd0, ws}, 32'd2);
    axi_read(5'h1C, rd, rs);
    check_eq("unmap_rdata", rd, 32'd0);
    check_eq("unmap_rresp", {30'd0, rs}, 32'd2);
    axi_write(5'h0C, 32'hFFFF_FFFF, 4'hF, ws); check_eq("status_wr_resp", {30'd0, ws}, 32'd0);
    axi_read(5'h04, rd, rs); check_eq("unmap_len_kept", rd, 32'h0000_CC40);
    axi_read(5'h00, rd, rs); check_eq("unmap_ctrl_kept", rd, 32'd0);

    // Reset while a response and a message word are outstanding
    axi_write(5'h08, 32'h3333_3333, 4'hF, ws);
    @(negedge clk);
    s00_axi.awaddr = 5'h00; s00_axi.awvalid = 1'b1;
    s00_axi.wdata = 32'h4; s00_axi.wstrb = 4'hF; s00_axi.wvalid = 1'b1;
    @(posedge clk); #1; s00_axi.awvalid = 1'b0; s00_axi.wvalid = 1'b0;
    @(negedge clk);
    check_eq("mid_bvalid", {31'd0, s00_axi.bvalid}, 32'd1);
    check_eq("mid_msg_valid", {31'd0, msg_valid_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valids", {28'd0, s00_axi.bvalid, s00_axi.rvalid, msg_valid_o, start_o}, 32'd0);
    check_eq("mid_rst_readies", {29'd0, s00_axi.awready, s00_axi.wready, s00_axi.arready}, 32'd0);
    check_eq("mid_rst_msg_data", msg_data_o, 32'd0);
    check_eq("mid_rst_msg_len", msg_len_o, 32'd0);
    check_eq("mid_rst_resp", {28'd0, s00_axi.bresp, s00_axi.rresp}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    axi_read(5'h00, rd, rs); check_eq("post_rst_ctrl", rd, 32'd0);
    axi_read(5'h0C, rd, rs); check_eq("post_rst_status", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sha3_lite_axil_slave.md
# sha3_lite_axil_slave

AXI4-Lite slave register interface for the SHA3 lite core (1344-bit output). It sits between the block-design AXI interconnect (S00_AXI) and the hash core. It accepts control, length and message-word writes from the host, streams message words to the core, and exposes status and the 42-word digest for host readback.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; addr[4:2] selects the register.
- DIGEST_WORDS, 42, number of 32-bit digest words (1344/32).

- s00_axi_aclk, in, 1, single clock for all logic.
- s00_axi_aresetn, in, 1, reset; asynchronous assert, active-low.
- s00_axi_awaddr / awprot / awvalid / awready, in/in/in/out, 5/3/1/1, write address channel; awprot is ignored.
- s00_axi_wdata / wstrb / wvalid / wready, in/in/in/out, 32/4/1/1, write data channel.
- s00_axi_bresp / bvalid / bready, out/out/in, 2/1/1, write response channel.
- s00_axi_araddr / arprot / arvalid / arready, in/in/in/out, 5/3/1/1, read address channel; arprot is ignored.
- s00_axi_rdata / rresp / rvalid / rready, out/out/out/in, 32/2/1/1, read data channel.
- start_o, out, 1, one-cycle pulse that starts the core.
- msg_len_o, out, 32, message length in bytes (the MSG_LEN register).
- msg_data_o / msg_valid_o / msg_ready_i, out/out/in, 32/1/1, message word stream to the core.
- busy_i, in, 1, core busy level.
- done_i, in, 1, one-cycle pulse from the core; digest_i is valid in that cycle.
- digest_i, in, 1344, digest from the core; word 0 = bits [31:0].

## Operation
- Register map:
  - 0x00 CTRL, RW. A write with wdata[0]=1 pulses start_o and clears the DONE bit. Stored bits [31:1] read back; bit 0 always reads 0.
  - 0x04 MSG_LEN, RW. Byte-masked by wstrb; drives msg_len_o.
  - 0x08 MSG_DATA, WO. A write loads msg_data_o and sets msg_valid_o. wstrb is ignored. Reads return the last pushed word.
  - 0x0C STATUS, RO. bit0 = busy_i; bit1 = DONE (sticky, set by done_i); bit2 = msg_valid_o; bits[13:8] = digest read pointer. Writes are ignored and respond OKAY.
  - 0x10 DIGEST, RO. A read returns digest word[ptr], then ptr increments; ptr wraps from 41 to 0. ptr resets to 0 on done_i.
  - 0x14–0x1C unmapped. Writes have no effect and respond SLVERR (2'b10); reads return 0 with SLVERR.
- done_i latches digest_i into an internal 1344-bit register and sets DONE. If done_i and a CTRL start write occur in the same cycle, DONE ends set.
- Write path: AW and W are accepted independently into one-entry holding registers.
  - awready is high when the AW holder is empty and bvalid=0; wready follows the same rule for W.
  - The write executes in the first cycle both holders are full. Exception: for MSG_DATA, the write waits while msg_valid_o=1 and msg_ready_i=0.
  - On execute: bvalid rises and both holders clear.
  - bvalid stays high until bready.
- Read path: arready is high when rvalid=0.
  - On an AR handshake, rdata/rresp are registered and rvalid rises the next cycle.
  - rvalid and rdata stay stable until rready.
- Message stream: msg_valid_o falls in the cycle after msg_ready_i is sampled high. A new MSG_DATA write may execute in that same handshake cycle, keeping msg_valid_o high with the new word.

## Timing
- Reset values: all outputs 0 (awready, wready, arready, bvalid, rvalid, start_o, msg_valid_o, msg_data_o, msg_len_o, rdata, bresp, rresp). Registers, ptr, DONE and the digest store are also 0.
- Reset can assert mid-transaction. Pending AW/W/AR transactions are dropped and every valid falls asynchronously.
- The first handshake is possible on the first rising edge after reset deassertion.
- Write latency: with AW and W in the same cycle, bvalid is high in the next cycle and start_o pulses in that same cycle.
- With AW first and W k cycles later, bvalid rises 1 cycle after the W handshake.
- Read latency: rvalid is high 1 cycle after the AR handshake.
- DIGEST pointer advance happens on the AR handshake, not on the R handshake.
- Back-to-back throughput: one write per 2 cycles when bready is held high; same for reads.

## Test plan
- Reset and register readback:
  - Write 0x00000002 to CTRL and 0x00000040 to MSG_LEN.
  - Read back 0x00000002 and 0x00000040, both OKAY.
  - msg_len_o=0x40.
  - start_o never pulses.
- Write channel skew and byte strobes:
  - Issue AW 3 cycles before W on MSG_LEN.
  - bvalid rises exactly 1 cycle after the W handshake.
  - A wstrb=4'b0010 write of 0xAABBCCDD over 0x00000040 reads back 0x0000CC40.
- Message backpressure:
  - Hold msg_ready_i=0 and write 0x11111111, then 0x22222222, to MSG_DATA.
  - The second bvalid is withheld until msg_ready_i pulses.
  - The core sees 0x11111111, then 0x22222222, with no word lost.
- Start and digest readback:
  - Write CTRL=1: start_o pulses 1 cycle.
  - Pulse done_i with digest_i word n = n+0x100. STATUS reads bit1=1, ptr=0.
  - 43 DIGEST reads return 0x100…0x129, then 0x100 again (wrap).
  - CTRL=1 clears DONE.
- Unmapped access: write 0x14 and read 0x1C.
  - bresp=2'b10 and rresp=2'b10, rdata=0.
  - No register changes.
- Reset mid-operation:
  - Assert s00_axi_aresetn low while bvalid=1 and msg_valid_o=1.
  - All outputs are 0 immediately.
  - After release, a CTRL read returns 0.
